// File: rtl/dmrfy_sched.sv
// dmrfy_sched: ping-pong scheduler for the two DMRF-Y banks; steers the load stream into a
// free bank and sweeps exec read addresses over the other, overlapping fill and drain.
module dmrfy_sched #(
    parameter int AXIS_LOAD_DATA_WIDTH = 256,
    parameter int LOAD_ADDR_WIDTH      = 5,
    parameter int EXEC_ADDR_WIDTH      = 5,
    parameter int REPEAT_WIDTH         = 8,
    parameter int EXEC_LAT             = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            ctrl_clear,
    input  logic [LOAD_ADDR_WIDTH-1:0]      cfg_load_depth,
    input  logic [EXEC_ADDR_WIDTH-1:0]      cfg_exec_depth,
    input  logic [REPEAT_WIDTH-1:0]         cfg_exec_repeat,
    input  logic [AXIS_LOAD_DATA_WIDTH-1:0] s_axis_load_tdata,
    input  logic                            s_axis_load_tvalid,
    output logic                            s_axis_load_tready,
    output logic [AXIS_LOAD_DATA_WIDTH-1:0] m_axis_dmrfy0_load_tdata,
    output logic                            m_axis_dmrfy0_load_tvalid,
    input  logic                            m_axis_dmrfy0_load_tready,
    output logic [AXIS_LOAD_DATA_WIDTH-1:0] m_axis_dmrfy1_load_tdata,
    output logic                            m_axis_dmrfy1_load_tvalid,
    input  logic                            m_axis_dmrfy1_load_tready,
    output logic [LOAD_ADDR_WIDTH-1:0]      dmrfy_load_depth,
    input  logic                            dmrfy0_load_done,
    input  logic                            dmrfy1_load_done,
    input  logic                            exec_en,
    output logic [EXEC_ADDR_WIDTH-1:0]      dmrfy_exec_addr,
    output logic                            exec_valid,
    output logic                            exec_bank,
    output logic                            exec_data_valid,
    output logic                            exec_data_last,
    output logic [1:0]                      bank_full,
    output logic                            busy
);
    typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAIN} bank_st_e;

    bank_st_e                   st_q [2];
    bank_st_e                   st_d [2];
    logic                       ld_ptr_q, ld_ptr_d, ex_ptr_q, ex_ptr_d, ev_q, ev_d;
    logic [EXEC_ADDR_WIDTH-1:0] addr_q, addr_d, depth_q, depth_d;
    logic [REPEAT_WIDTH-1:0]    pass_q, pass_d, rep_q, rep_d;
    logic [EXEC_LAT-1:0]        dv_q, dv_d, dl_q, dl_d, db_q, db_d;
    logic [EXEC_LAT:0]          dv_s, dl_s, db_s;
    logic [1:0]                 done;
    logic                       filling, fire, final_beat;

    assign done       = {dmrfy1_load_done, dmrfy0_load_done};
    assign filling    = st_q[ld_ptr_q] == FILLING;
    assign fire       = ev_q & exec_en;
    assign final_beat = fire && addr_q == depth_q && pass_q == rep_q;

    assign s_axis_load_tready        = filling & (ld_ptr_q ? m_axis_dmrfy1_load_tready : m_axis_dmrfy0_load_tready);
    assign m_axis_dmrfy0_load_tvalid = filling & ~ld_ptr_q & s_axis_load_tvalid;
    assign m_axis_dmrfy1_load_tvalid = filling & ld_ptr_q & s_axis_load_tvalid;
    assign m_axis_dmrfy0_load_tdata  = filling ? s_axis_load_tdata : '0;
    assign m_axis_dmrfy1_load_tdata  = filling ? s_axis_load_tdata : '0;
    assign dmrfy_load_depth          = cfg_load_depth;

    assign dmrfy_exec_addr = addr_q;
    assign exec_valid      = ev_q;
    assign exec_bank       = db_q[EXEC_LAT-1];
    assign exec_data_valid = dv_q[EXEC_LAT-1];
    assign exec_data_last  = dl_q[EXEC_LAT-1];
    assign bank_full       = {st_q[1] == FULL || st_q[1] == DRAIN, st_q[0] == FULL || st_q[0] == DRAIN};
    assign busy            = st_q[0] != EMPTY || st_q[1] != EMPTY;

    assign dv_s = {dv_q, fire};
    assign dl_s = {dl_q, final_beat};
    assign db_s = {db_q, ex_ptr_q};

    always_comb begin
        st_d[0]  = st_q[0];
        st_d[1]  = st_q[1];
        ld_ptr_d = ld_ptr_q;
        ex_ptr_d = ex_ptr_q;
        ev_d     = ev_q;
        addr_d   = addr_q;
        pass_d   = pass_q;
        depth_d  = depth_q;
        rep_d    = rep_q;
        dv_d     = dv_s[EXEC_LAT-1:0];
        dl_d     = dl_s[EXEC_LAT-1:0];
        db_d     = db_s[EXEC_LAT-1:0];
        // Load and exec never touch the same bank: load owns EMPTY/FILLING, exec owns FULL/DRAIN.
        if (st_q[ld_ptr_q] == EMPTY) begin
            st_d[ld_ptr_q] = FILLING;
        end else if (filling && done[ld_ptr_q]) begin
            st_d[ld_ptr_q] = FULL;
            ld_ptr_d       = ~ld_ptr_q;
        end
        if (!ev_q) begin
            if (st_q[ex_ptr_q] == FULL) begin
                st_d[ex_ptr_q] = DRAIN;
                ev_d           = 1'b1;
                addr_d         = '0;
                pass_d         = '0;
                depth_d        = cfg_exec_depth;
                rep_d          = cfg_exec_repeat;
            end
        end else if (exec_en) begin
            if (addr_q != depth_q) begin
                addr_d = addr_q + 1'b1;
            end else if (pass_q != rep_q) begin
                addr_d = '0;
                pass_d = pass_q + 1'b1;
            end else begin
                addr_d         = '0;
                pass_d         = '0;
                st_d[ex_ptr_q] = EMPTY;
                ex_ptr_d       = ~ex_ptr_q;
                // Chain straight into the other bank when it is already waiting.
                if (st_q[~ex_ptr_q] == FULL) begin
                    st_d[~ex_ptr_q] = DRAIN;
                    depth_d         = cfg_exec_depth;
                    rep_d           = cfg_exec_repeat;
                end else begin
                    ev_d = 1'b0;
                end
            end
        end
        if (ctrl_clear) begin
            st_d[0]  = EMPTY;
            st_d[1]  = EMPTY;
            ld_ptr_d = 1'b0;
            ex_ptr_d = 1'b0;
            ev_d     = 1'b0;
            addr_d   = '0;
            pass_d   = '0;
            depth_d  = '0;
            rep_d    = '0;
            dv_d     = '0;
            dl_d     = '0;
            db_d     = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q[0]  <= EMPTY;
            st_q[1]  <= EMPTY;
            ld_ptr_q <= 1'b0;
            ex_ptr_q <= 1'b0;
            ev_q     <= 1'b0;
            addr_q   <= '0;
            pass_q   <= '0;
            depth_q  <= '0;
            rep_q    <= '0;
            dv_q     <= '0;
            dl_q     <= '0;
            db_q     <= '0;
        end else begin
            st_q[0]  <= st_d[0];
            st_q[1]  <= st_d[1];
            ld_ptr_q <= ld_ptr_d;
            ex_ptr_q <= ex_ptr_d;
            ev_q     <= ev_d;
            addr_q   <= addr_d;
            pass_q   <= pass_d;
            depth_q  <= depth_d;
            rep_q    <= rep_d;
            dv_q     <= dv_d;
            dl_q     <= dl_d;
            db_q     <= db_d;
        end
    end
endmodule

// File: tb/tb_dmrfy_sched.sv
// tb_dmrfy_sched: random stimulus against a beat-count reference model of the bank scheduler.
module tb_dmrfy_sched;
    localparam int DW = 256, LW = 5, EW = 5, RW = 8, LAT = 2;
    localparam int M_EMPTY = 0, M_FILL = 1, M_FULL = 2, M_DRAIN = 3;

    logic          clk = 1'b0, rst_n = 1'b0, ctrl_clear = 1'b0;
    logic [LW-1:0] cfg_load_depth = '0;
    logic [EW-1:0] cfg_exec_depth = '0;
    logic [RW-1:0] cfg_exec_repeat = '0;
    logic [DW-1:0] s_tdata = '0, m0_tdata, m1_tdata;
    logic          s_tvalid = 1'b0, s_tready, m0_tvalid, m1_tvalid;
    logic          m0_tready = 1'b0, m1_tready = 1'b0, done0 = 1'b0, done1 = 1'b0, exec_en = 1'b0;
    logic [LW-1:0] load_depth;
    logic [EW-1:0] exec_addr;
    logic          exec_valid, exec_bank, dvalid, dlast, busy;
    logic [1:0]    bank_full;

    dmrfy_sched #(.AXIS_LOAD_DATA_WIDTH(DW), .LOAD_ADDR_WIDTH(LW), .EXEC_ADDR_WIDTH(EW),
                  .REPEAT_WIDTH(RW), .EXEC_LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .ctrl_clear(ctrl_clear),
        .cfg_load_depth(cfg_load_depth), .cfg_exec_depth(cfg_exec_depth), .cfg_exec_repeat(cfg_exec_repeat),
        .s_axis_load_tdata(s_tdata), .s_axis_load_tvalid(s_tvalid), .s_axis_load_tready(s_tready),
        .m_axis_dmrfy0_load_tdata(m0_tdata), .m_axis_dmrfy0_load_tvalid(m0_tvalid),
        .m_axis_dmrfy0_load_tready(m0_tready),
        .m_axis_dmrfy1_load_tdata(m1_tdata), .m_axis_dmrfy1_load_tvalid(m1_tvalid),
        .m_axis_dmrfy1_load_tready(m1_tready),
        .dmrfy_load_depth(load_depth), .dmrfy0_load_done(done0), .dmrfy1_load_done(done1),
        .exec_en(exec_en), .dmrfy_exec_addr(exec_addr), .exec_valid(exec_valid), .exec_bank(exec_bank),
        .exec_data_valid(dvalid), .exec_data_last(dlast), .bank_full(bank_full), .busy(busy));

    always #5 clk = ~clk;

    int n_chk = 0, n_bad = 0;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: an exec sweep is a run of (depth+1)*(repeat+1) beats; addr is beat mod (depth+1).
    int st [2];
    int ld, ex, beat, total, dep;
    bit act;
    bit vq[$], lq[$], bq[$];

    task automatic model_reset();
        st[0] = M_EMPTY; st[1] = M_EMPTY;
        ld = 0; ex = 0; act = 0; beat = 0; total = 1; dep = 0;
        vq = {}; lq = {}; bq = {};
        for (int i = 0; i < LAT; i++) begin
            vq.push_back(1'b0); lq.push_back(1'b0); bq.push_back(1'b0);
        end
    endtask

    task automatic latch_cfg();
        dep   = int'(cfg_exec_depth);
        total = (dep + 1) * (int'(cfg_exec_repeat) + 1);
        beat  = 0;
    endtask

    task automatic model_step();
        int nst [2];
        int nld, nex;
        bit fin, d;
        fin = act && exec_en && beat == total - 1;
        vq.push_back(act && exec_en); lq.push_back(fin); bq.push_back(ex[0]);
        void'(vq.pop_front()); void'(lq.pop_front()); void'(bq.pop_front());
        if (ctrl_clear) begin
            model_reset();
            return;
        end
        nst = st; nld = ld; nex = ex;
        d = (ld == 0) ? done0 : done1;
        if (st[ld] == M_EMPTY) nst[ld] = M_FILL;
        else if (st[ld] == M_FILL && d) begin
            nst[ld] = M_FULL;
            nld = 1 - ld;
        end
        if (!act) begin
            if (st[ex] == M_FULL) begin
                nst[ex] = M_DRAIN; act = 1; latch_cfg();
            end
        end else if (exec_en) begin
            if (fin) begin
                nst[ex] = M_EMPTY; nex = 1 - ex;
                if (st[1 - ex] == M_FULL) begin
                    nst[1 - ex] = M_DRAIN; latch_cfg();
                end else begin
                    act = 0; beat = 0;
                end
            end else beat++;
        end
        st = nst; ld = nld; ex = nex;
    endtask

    task automatic check_outputs();
        bit fill;
        fill = st[ld] == M_FILL;
        chk("tready", s_tready, fill && ((ld == 0) ? m0_tready : m1_tready));
        chk("m0_tvalid", m0_tvalid, fill && ld == 0 && s_tvalid);
        chk("m1_tvalid", m1_tvalid, fill && ld == 1 && s_tvalid);
        chk("m0_tdata", m0_tdata, fill ? s_tdata : '0);
        chk("m1_tdata", m1_tdata, fill ? s_tdata : '0);
        chk("load_depth", load_depth, cfg_load_depth);
        chk("exec_valid", exec_valid, act);
        chk("exec_addr", exec_addr, act ? beat % (dep + 1) : 0);
        chk("bank_full", bank_full, {st[1] >= M_FULL, st[0] >= M_FULL});
        chk("busy", busy, st[0] != M_EMPTY || st[1] != M_EMPTY);
        chk("data_valid", dvalid, vq[0]);
        chk("data_last", dlast, lq[0]);
        chk("exec_bank", exec_bank, bq[0]);
    endtask

    initial begin
        int en_pct;
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset_exec_valid", exec_valid, 1'b0);
        chk("reset_busy", busy, 1'b0);
        rst_n = 1'b1;
        for (int cyc = 0; cyc < 6000; cyc++) begin
            if (cyc % 700 == 350) begin
                #2 rst_n = 1'b0;
                #1;
                chk("async_exec_valid", exec_valid, 1'b0);
                chk("async_addr", exec_addr, '0);
                chk("async_bank_full", bank_full, 2'b00);
                chk("async_busy", busy, 1'b0);
                chk("async_tready", s_tready, 1'b0);
                chk("async_data_valid", dvalid, 1'b0);
                chk("async_data_last", dlast, 1'b0);
                model_reset();
                @(negedge clk);
                rst_n = 1'b1;
            end
            en_pct = ((cyc / 500) % 2 == 0) ? 50 : 95;
            ctrl_clear      = $urandom_range(0, 249) == 0;
            cfg_load_depth  = LW'($urandom);
            cfg_exec_depth  = ($urandom_range(0, 15) == 0) ? EW'(31) : EW'($urandom_range(0, 4));
            cfg_exec_repeat = RW'($urandom_range(0, 2));
            for (int i = 0; i < DW / 32; i++) s_tdata[i*32 +: 32] = $urandom;
            s_tvalid  = $urandom_range(0, 99) < 70;
            m0_tready = $urandom_range(0, 99) < 70;
            m1_tready = $urandom_range(0, 99) < 70;
            done0     = $urandom_range(0, 99) < 20;
            done1     = $urandom_range(0, 99) < 20;
            exec_en   = $urandom_range(0, 99) < en_pct;
            #1;
            check_outputs();
            model_step();
            @(negedge clk);
        end
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
